// File: rtl/bus_timer.sv
// Memory-mapped interval timer on the CPU tagged bus: 4-word register window,
// prescaled down-counter with optional auto-reload, and a level interrupt.
module bus_timer #(
  parameter logic [19:0] BASE     = 20'hFFFF0,
  parameter int          PRESCALE = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [63:0] i_ad,
  input  logic [7:0]  i_tag,
  input  logic        i_astb,
  input  logic        i_atomic,
  input  logic        i_rd,
  input  logic        i_wr,
  output logic [63:0] o_data,
  output logic [7:0]  o_tag,
  output logic        o_sel,
  output logic        o_irq
);

  localparam logic [16:0] PMAX = 17'(PRESCALE - 1);

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PERIOD = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  logic [19:0] waddr;
  logic        hit;
  logic [2:0]  ctrl;
  logic [31:0] period;
  logic [31:0] count;
  logic        pend;
  logic        ovf;
  logic [16:0] presc;

  logic        wr_hit, rd_hit;
  logic        wr_ctrl, wr_period, wr_count, wr_status;
  logic        tick, tick_eff, expire;
  logic        clr_pend, clr_ovf;
  logic [63:0] rd_val;
  logic        unused_bits;

  // Bus protocol: i_astb latches the word address and decode result; any
  // number of i_rd/i_wr cycles may follow. A strobe cycle never reads/writes.
  always_comb begin
    wr_hit    = i_wr & ~i_astb & hit;
    rd_hit    = i_rd & ~i_astb & hit;
    wr_ctrl   = wr_hit & (waddr[1:0] == REG_CTRL);
    wr_period = wr_hit & (waddr[1:0] == REG_PERIOD);
    wr_count  = wr_hit & (waddr[1:0] == REG_COUNT);
    wr_status = wr_hit & (waddr[1:0] == REG_STATUS);
  end

  // A same-cycle CPU write to COUNT overrides the whole tick, expiry included.
  always_comb begin
    tick     = ctrl[0] & (presc == PMAX);
    tick_eff = tick & ~wr_count;
    expire   = tick_eff & (count == 32'd1);
    clr_pend = (wr_status & i_ad[0]) |
               (rd_hit & i_atomic & (waddr[1:0] == REG_STATUS));
    clr_ovf  = (wr_status & i_ad[1]) |
               (rd_hit & i_atomic & (waddr[1:0] == REG_STATUS));
  end

  always_comb begin
    rd_val = '0;
    case (waddr[1:0])
      REG_CTRL:   rd_val = {61'd0, ctrl};
      REG_PERIOD: rd_val = {32'd0, period};
      REG_COUNT:  rd_val = {32'd0, count};
      REG_STATUS: rd_val = {62'd0, ovf, pend};
      default:    rd_val = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      waddr <= '0;
      hit   <= 1'b0;
    end else if (i_astb) begin
      waddr <= i_ad[19:0];
      hit   <= (i_ad[19:2] == BASE[19:2]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      presc <= '0;
    end else if (!ctrl[0] || wr_ctrl || wr_count || tick) begin
      presc <= '0;
    end else begin
      presc <= presc + 17'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl   <= '0;
      period <= '0;
      count  <= '0;
      pend   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= i_ad[2:0];
      end else if (expire && !ctrl[1]) begin
        ctrl[0] <= 1'b0;
      end

      if (wr_period) begin
        period <= i_ad[31:0];
      end

      if (wr_count) begin
        count <= i_ad[31:0];
      end else if (tick_eff && count > 32'd1) begin
        count <= count - 32'd1;
      end else if (expire) begin
        count <= ctrl[1] ? period : 32'd0;
      end

      // Expiry setting a flag wins over any same-cycle clear.
      if (expire) begin
        pend <= 1'b1;
      end else if (clr_pend) begin
        pend <= 1'b0;
      end

      if (expire && pend) begin
        ovf <= 1'b1;
      end else if (clr_ovf) begin
        ovf <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_data <= '0;
      o_sel  <= 1'b0;
    end else begin
      o_data <= rd_hit ? rd_val : 64'd0;
      o_sel  <= rd_hit;
    end
  end

  assign o_tag = 8'd0;
  assign o_irq = pend & ctrl[2];

  assign unused_bits = &{1'b0, i_tag, i_ad[63:32], waddr[19:2]};

endmodule

// File: tb/tb_bus_timer.sv
// Directed bench for bus_timer: register access, one-shot and auto-reload
// expiry, atomic status reads, decode misses and asynchronous reset.
module tb_bus_timer;

  localparam logic [19:0] BASE     = 20'hFFFF0;
  localparam int          PRESCALE = 16;

  logic        clk;
  logic        reset_n;
  logic [63:0] i_ad;
  logic [7:0]  i_tag;
  logic        i_astb;
  logic        i_atomic;
  logic        i_rd;
  logic        i_wr;
  logic [63:0] o_data;
  logic [7:0]  o_tag;
  logic        o_sel;
  logic        o_irq;

  int n_checks;
  int n_errors;
  logic [63:0] exp_q[$];

  bus_timer #(.BASE(BASE), .PRESCALE(PRESCALE)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .i_ad     (i_ad),
    .i_tag    (i_tag),
    .i_astb   (i_astb),
    .i_atomic (i_atomic),
    .i_rd     (i_rd),
    .i_wr     (i_wr),
    .o_data   (o_data),
    .o_tag    (o_tag),
    .o_sel    (o_sel),
    .o_irq    (o_irq)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // driver tasks: each starts and ends just after a falling edge
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic strobe(input logic [19:0] a);
    i_astb = 1'b1;
    i_ad   = {44'd0, a};
    @(negedge clk);
    i_astb = 1'b0;
    i_ad   = '0;
  endtask

  task automatic wr_reg(input logic [1:0] r, input logic [63:0] d);
    strobe(BASE + {18'd0, r});
    i_wr = 1'b1;
    i_ad = d;
    @(negedge clk);
    i_wr = 1'b0;
    i_ad = '0;
  endtask

  task automatic rd_reg(input logic [1:0] r, input logic atomic, input string tag,
                        input logic [63:0] exp);
    strobe(BASE + {18'd0, r});
    exp_q.push_back(exp);
    i_rd     = 1'b1;
    i_atomic = atomic;
    @(negedge clk);
    i_rd     = 1'b0;
    i_atomic = 1'b0;
    check(tag, o_data, exp_q.pop_front());
    check({tag, "_sel"}, {63'd0, o_sel}, 64'd1);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset_n  = 1'b0;
    i_ad     = {44'd0, BASE + 20'd3};
    i_tag    = 8'hA5;
    i_astb   = 1'b1;
    i_atomic = 1'b0;
    i_rd     = 1'b1;
    i_wr     = 1'b0;

    // Reset held with bus activity: all outputs stay zero.
    idle(3);
    check("rst_data", o_data, 64'd0);
    check("rst_sel",  {63'd0, o_sel}, 64'd0);
    check("rst_tag",  {56'd0, o_tag}, 64'd0);
    check("rst_irq",  {63'd0, o_irq}, 64'd0);
    i_astb  = 1'b0;
    i_rd    = 1'b0;
    i_ad    = '0;
    reset_n = 1'b1;
    idle(1);
    rd_reg(2'd3, 1'b0, "rst_status", 64'd0);
    idle(1);
    check("rst_sel_drop", {63'd0, o_sel}, 64'd0);

    // One-shot: 3 ticks of 16 cycles after the CTRL write.
    wr_reg(2'd1, 64'd3);
    wr_reg(2'd2, 64'd3);
    wr_reg(2'd0, 64'd5);
    idle(47);
    check("oneshot_irq_early", {63'd0, o_irq}, 64'd0);
    idle(1);
    check("oneshot_irq", {63'd0, o_irq}, 64'd1);
    rd_reg(2'd2, 1'b0, "oneshot_count", 64'd0);
    rd_reg(2'd0, 1'b0, "oneshot_ctrl", 64'd4);
    rd_reg(2'd3, 1'b0, "oneshot_status", 64'd1);
    wr_reg(2'd3, 64'd3);
    check("oneshot_clr_irq", {63'd0, o_irq}, 64'd0);

    // Auto-reload: expiries at 32 and 64 cycles, second one sets OVF.
    wr_reg(2'd2, 64'd2);
    wr_reg(2'd1, 64'd2);
    wr_reg(2'd0, 64'd7);
    idle(66);
    rd_reg(2'd3, 1'b0, "auto_status", 64'd3);
    wr_reg(2'd3, 64'd1);
    check("auto_w1c_irq", {63'd0, o_irq}, 64'd0);
    rd_reg(2'd3, 1'b0, "auto_status_w1c", 64'd2);
    wr_reg(2'd0, 64'd0);
    wr_reg(2'd3, 64'd3);
    rd_reg(2'd3, 1'b0, "auto_status_clr", 64'd0);

    // Atomic read of STATUS clears PEND.
    wr_reg(2'd2, 64'd1);
    wr_reg(2'd0, 64'd5);
    idle(20);
    check("atomic_irq", {63'd0, o_irq}, 64'd1);
    rd_reg(2'd3, 1'b1, "atomic_stat", 64'd1);
    rd_reg(2'd3, 1'b0, "after_atomic", 64'd0);
    check("atomic_irq_clr", {63'd0, o_irq}, 64'd0);

    // Atomic read on the expiry edge: old value returned, PEND survives.
    wr_reg(2'd2, 64'd1);
    wr_reg(2'd0, 64'd5);
    idle(14);
    rd_reg(2'd3, 1'b1, "atomic_race", 64'd0);
    rd_reg(2'd3, 1'b0, "race_pend", 64'd1);
    check("race_irq", {63'd0, o_irq}, 64'd1);
    wr_reg(2'd3, 64'd3);
    wr_reg(2'd0, 64'd0);

    // Decode: upper write data ignored, miss window, strobe-cycle write.
    wr_reg(2'd1, 64'hFFFF_FFFF_0000_1234);
    rd_reg(2'd1, 1'b0, "period_upper", 64'h1234);
    strobe(BASE + 20'd4);
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    check("miss_sel", {63'd0, o_sel}, 64'd0);
    check("miss_data", o_data, 64'd0);
    strobe(BASE + 20'd5);
    i_wr = 1'b1;
    i_ad = 64'hDEAD;
    @(negedge clk);
    i_wr = 1'b0;
    i_ad = '0;
    rd_reg(2'd1, 1'b0, "miss_wr_period", 64'h1234);
    i_astb = 1'b1;
    i_wr   = 1'b1;
    i_ad   = {44'd0, BASE + 20'd1};
    @(negedge clk);
    i_astb = 1'b0;
    i_wr   = 1'b0;
    i_ad   = '0;
    rd_reg(2'd1, 1'b0, "astb_wr_period", 64'h1234);

    // Back-to-back reads after one strobe.
    strobe(BASE + 20'd1);
    i_rd = 1'b1;
    @(negedge clk);
    check("b2b_data0", o_data, 64'h1234);
    @(negedge clk);
    i_rd = 1'b0;
    check("b2b_data1", o_data, 64'h1234);
    check("b2b_sel1", {63'd0, o_sel}, 64'd1);
    @(negedge clk);
    check("b2b_sel_drop", {63'd0, o_sel}, 64'd0);

    // Async reset mid-count with PEND set and a read in flight.
    wr_reg(2'd2, 64'd1);
    wr_reg(2'd0, 64'd5);
    idle(20);
    wr_reg(2'd2, 64'd5);
    wr_reg(2'd0, 64'd5);
    idle(20);
    check("pre_rst_irq", {63'd0, o_irq}, 64'd1);
    strobe(BASE + 20'd3);
    i_rd = 1'b1;
    @(negedge clk);
    i_rd = 1'b0;
    check("pre_rst_sel", {63'd0, o_sel}, 64'd1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_sel",  {63'd0, o_sel}, 64'd0);
    check("mid_rst_data", o_data, 64'd0);
    check("mid_rst_irq",  {63'd0, o_irq}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(100);
    check("post_rst_irq", {63'd0, o_irq}, 64'd0);
    rd_reg(2'd2, 1'b0, "post_rst_count", 64'd0);
    rd_reg(2'd0, 1'b0, "post_rst_ctrl", 64'd0);
    rd_reg(2'd3, 1'b0, "post_rst_status", 64'd0);

    // final report
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/bus_timer.md
# bus_timer

Memory-mapped interval timer on the CPU tagged bus, sitting next to the tagged RAM as a second consumer of the CPU's address/data, strobe and read/write outputs. It decodes a 4-word window, holds a programmable down-counter with prescaler, and raises a level interrupt request when the count expires. Read data is returned on a separate registered path with a select flag, so the system muxes it with RAM read data into the CPU's data and tag inputs.

## Interface
- BASE, 20'hFFFF0: word address of register 0; must be a multiple of 4; window is BASE..BASE+3.
- PRESCALE, 16: clock cycles per timer tick, 1..65536.
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  reset, asynchronous and active-low.
- i_ad  in  64  CPU address/data output: word address in [19:0] during i_astb, write data during i_wr.
- i_tag  in  8  CPU tag output; ignored.
- i_astb  in  1  address strobe.
- i_atomic  in  1  read-modify-write flag, qualifies i_rd.
- i_rd  in  1  read op.
- i_wr  in  1  write op.
- o_data  out  64  read data, zero when o_sel=0.
- o_tag  out  8  read tag, always 0.
- o_sel  out  1  o_data is valid and overrides RAM data this cycle.
- o_irq  out  1  interrupt request, level.

## Operation
- Address latch: on i_astb, waddr <= i_ad[19:0]; hit <= (i_ad[19:2] == BASE[19:2]). Held until next i_astb; any number of rd/wr may follow one strobe.
- i_astb has priority: i_rd/i_wr in the same cycle as i_astb are ignored.
- Registers (reg = waddr[1:0]):
  - 0 CTRL [2:0]: bit0 EN, bit1 AUTO (auto-reload), bit2 IE. Upper bits read 0.
  - 1 PERIOD [31:0]: reload value.
  - 2 COUNT [31:0]: current count; writable.
  - 3 STATUS [1:0]: bit0 PEND, bit1 OVF. Write-1-to-clear.
- Unused data bits read 0; writes ignore i_ad[63:32].
- Prescaler: counts 0..PRESCALE-1 while EN=1; tick on wrap to 0. Cleared when EN=0 and on any write to CTRL or COUNT.
- On tick: if COUNT>1, COUNT-1. If COUNT==1: set PEND, and OVF if PEND already set; then COUNT<=PERIOD if AUTO, else COUNT<=0 and EN<=0. If COUNT==0: no action.
- o_irq = PEND & IE (combinational from registers).
- Atomic read (i_rd & i_atomic) of STATUS: returns current value, clears PEND and OVF on the same edge. Atomic read of other registers behaves as a plain read.
- Simultaneous events: expiry set beats any same-cycle clear (W1C write or atomic read); CPU write to COUNT beats same-cycle tick; CPU write to CTRL.EN=0 beats same-cycle auto-clear.
- Non-hit rd/wr: no state change, o_sel stays 0.

## Timing
- Reset (async, reset_n low): CTRL=0, PERIOD=0, COUNT=0, STATUS=0, prescaler=0, waddr=0, hit=0, o_data=0, o_tag=0, o_sel=0, o_irq=0.
- Read latency 1: i_rd sampled at edge N with hit=1 -> o_data/o_sel valid for the cycle after edge N, exactly one cycle; back-to-back reads give back-to-back data.
- Write effect at the edge sampling i_wr; read issued the next cycle returns the new value.
- PEND, o_irq rise in the cycle after the edge where COUNT leaves 1.
- First tick occurs PRESCALE cycles after EN set (or COUNT written); from COUNT=K, PEND sets PRESCALE*K cycles after the write.
- Reset deasserts mid-operation: every register restarts from reset values; pending read data is dropped.

## Test plan
- Reset: hold reset_n=0, drive i_rd/i_astb -> all outputs 0; release, read STATUS at BASE+3 -> o_data=0, o_sel=1 one cycle.
- One-shot, PRESCALE=16: write PERIOD=3, COUNT=3, CTRL=5 -> o_irq rises 48 cycles after CTRL write, COUNT reads 0, CTRL reads 4.
- Auto-reload: COUNT=2, PERIOD=2, CTRL=7, no clear -> after 2nd expiry STATUS=3; write STATUS=1 -> STATUS=2, o_irq=0.
- Atomic read of STATUS with PEND=1 -> returns 1, next plain read 0; repeat with expiry on same edge -> returns 0, PEND still set.
- Decode: astb address BASE+4 then rd/wr -> o_sel stays 0, registers unchanged; astb and wr in same cycle -> write ignored.
- Async reset asserted mid-count (COUNT=5, EN=1) -> COUNT=0, o_irq=0 immediately, no expiry afterwards.
